l2_req_arbiter: RTL and testbench

Shares the single main-memory request port between three requesters: instruction-cache block reads, data-cache block reads, and data-cache write-backs. The block sits between the caches' L2 request/update ports and `main_memory`. It grants one requester at a time in round-robin order and keeps at most one read outstanding. Each read response is routed back to the requester that issued it.

---
 rtl/l2_req_arbiter_pkg.sv | 36 +++
 rtl/l2_req_arbiter_rr_pick3.sv | 54 +++++
 rtl/l2_req_arbiter.sv | 132 +++++++++++++
 tb/tb_l2_req_arbiter.sv | 565 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_req_arbiter_pkg.sv
// Shared types for the L2 request arbiter: FSM states, requester ids and the
// latched request record.
package l2_req_arbiter_pkg;

    // Request record fields are sized for the default build; the top casts to its own widths.
    localparam int L2_ADDR_BITS = 32;
    localparam int L2_DATA_BITS = 256;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } l2_arb_state_e;

    typedef enum logic [1:0] {
        IC_RD = 2'd0,
        DC_RD = 2'd1,
        DC_WR = 2'd2
    } l2_req_src_e;

    typedef struct packed {
        logic [L2_ADDR_BITS-1:0] addr;
        logic [L2_DATA_BITS-1:0] data;
        logic                    we;
        l2_req_src_e             src;
    } l2_req_t;

    function automatic l2_req_src_e src_after(input l2_req_src_e s);
        case (s)
            IC_RD:   return DC_RD;
            DC_RD:   return DC_WR;
            default: return IC_RD;
        endcase
    endfunction

endpackage

// File: rtl/l2_req_arbiter_rr_pick3.sv
// Combinational three-way picker returning a one-hot grant and the pointer to use next.
// L2_ARB_WRITE_PRIO_EN gives DC_WR fixed priority with IC_RD/DC_RD rotating.
module rr_pick3
    import l2_req_arbiter_pkg::*;
(
    input  logic [2:0]  req,
    input  l2_req_src_e ptr,
    output logic [2:0]  gnt,
    output l2_req_src_e ptr_next
);

`ifdef L2_ARB_WRITE_PRIO_EN
    // A write-back win leaves the read rotation untouched so reads stay fair.
    always_comb begin
        gnt      = 3'b000;
        ptr_next = ptr;
        if (req[DC_WR]) begin
            gnt = 3'b100;
        end else if (ptr == DC_RD) begin
            if (req[DC_RD]) begin
                gnt      = 3'b010;
                ptr_next = IC_RD;
            end else if (req[IC_RD]) begin
                gnt      = 3'b001;
                ptr_next = DC_RD;
            end
        end else begin
            if (req[IC_RD]) begin
                gnt      = 3'b001;
                ptr_next = DC_RD;
            end else if (req[DC_RD]) begin
                gnt      = 3'b010;
                ptr_next = IC_RD;
            end
        end
    end
`else
    l2_req_src_e cand;

    always_comb begin
        gnt      = 3'b000;
        ptr_next = ptr;
        cand     = ptr;
        for (int i = 0; i < 3; i++) begin
            if (gnt == 3'b000 && req[cand]) begin
                gnt[cand] = 1'b1;
                ptr_next  = src_after(cand);
            end
            cand = src_after(cand);
        end
    end
`endif

endmodule

// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing the main-memory port between icache reads, dcache reads
// and dcache write-backs, one read outstanding. Build option: L2_ARB_WRITE_PRIO_EN.
module l2_req_arbiter
    import l2_req_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = 32,
    parameter int IC_DW     = 256,
    parameter int DC_DW     = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ic_rd_valid_i,
    input  logic [ADDR_BITS-1:0] ic_rd_addr_i,
    output logic                 ic_rd_ready_o,
    output logic                 ic_resp_valid_o,
    output logic [IC_DW-1:0]     ic_resp_data_o,
    input  logic                 dc_rd_valid_i,
    input  logic [ADDR_BITS-1:0] dc_rd_addr_i,
    output logic                 dc_rd_ready_o,
    output logic                 dc_resp_valid_o,
    output logic [ADDR_BITS-1:0] dc_resp_addr_o,
    output logic [DC_DW-1:0]     dc_resp_data_o,
    input  logic                 dc_wr_valid_i,
    input  logic [ADDR_BITS-1:0] dc_wr_addr_i,
    input  logic [DC_DW-1:0]     dc_wr_data_i,
    output logic                 dc_wr_ready_o,
    output logic                 mem_valid_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [DC_DW-1:0]     mem_wdata_o,
    input  logic                 mem_ready_i,
    input  logic                 mem_resp_valid_i,
    input  logic [ADDR_BITS-1:0] mem_resp_addr_i,
    input  logic [DC_DW-1:0]     mem_resp_data_i,
    output logic                 err_o
);

    l2_arb_state_e state_q, state_d;
    l2_req_src_e   rr_ptr_q, rr_ptr_d, ptr_next;
    l2_req_t       req_q, req_d;
    logic          err_q, err_d;
    logic [2:0]    req_vec, gnt;
    logic          addr_match;

    assign req_vec    = {dc_wr_valid_i, dc_rd_valid_i, ic_rd_valid_i};
    assign addr_match = (mem_resp_addr_i == ADDR_BITS'(req_q.addr));

    rr_pick3 u_pick (
        .req      (req_vec),
        .ptr      (rr_ptr_q),
        .gnt      (gnt),
        .ptr_next (ptr_next)
    );

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        req_d           = req_q;
        err_d           = err_q;
        ic_rd_ready_o   = 1'b0;
        dc_rd_ready_o   = 1'b0;
        dc_wr_ready_o   = 1'b0;
        ic_resp_valid_o = 1'b0;
        dc_resp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    {dc_wr_ready_o, dc_rd_ready_o, ic_rd_ready_o} = gnt;
                    rr_ptr_d   = ptr_next;
                    state_d    = ISSUE;
                    req_d.we   = gnt[DC_WR];
                    req_d.data = gnt[DC_WR] ? L2_DATA_BITS'(dc_wr_data_i) : '0;
                    if (gnt[IC_RD]) begin
                        req_d.src  = IC_RD;
                        req_d.addr = L2_ADDR_BITS'(ic_rd_addr_i);
                    end else if (gnt[DC_RD]) begin
                        req_d.src  = DC_RD;
                        req_d.addr = L2_ADDR_BITS'(dc_rd_addr_i);
                    end else begin
                        req_d.src  = DC_WR;
                        req_d.addr = L2_ADDR_BITS'(dc_wr_addr_i);
                    end
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    state_d = req_q.we ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (mem_resp_valid_i) begin
                    if (addr_match) begin
                        ic_resp_valid_o = (req_q.src == IC_RD);
                        dc_resp_valid_o = (req_q.src == DC_RD);
                        state_d         = IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Includes a response landing in the same cycle as the read handshake.
        if (mem_resp_valid_i && state_q != WAIT_RESP) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= IC_RD;
            req_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= req_d;
            err_q    <= err_d;
        end
    end

    assign ic_resp_data_o = ic_resp_valid_o ? mem_resp_data_i[IC_DW-1:0] : '0;
    assign dc_resp_data_o = dc_resp_valid_o ? mem_resp_data_i : '0;
    assign dc_resp_addr_o = dc_resp_valid_o ? mem_resp_addr_i : '0;
    assign mem_valid_o    = (state_q == ISSUE);
    assign mem_we_o       = mem_valid_o & req_q.we;
    assign mem_addr_o     = ADDR_BITS'(req_q.addr);
    assign mem_wdata_o    = DC_DW'(req_q.data);
    assign err_o          = err_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration and routing rules.
`timescale 1ns/1ps
module tb_l2_req_arbiter;
    localparam int AW  = 32;
    localparam int IDW = 256;
    localparam int DDW = 256;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ic_rd_valid_i, dc_rd_valid_i, dc_wr_valid_i;
    logic [AW-1:0]  ic_rd_addr_i, dc_rd_addr_i, dc_wr_addr_i;
    logic [DDW-1:0] dc_wr_data_i;
    logic           ic_rd_ready_o, dc_rd_ready_o, dc_wr_ready_o;
    logic           ic_resp_valid_o, dc_resp_valid_o;
    logic [IDW-1:0] ic_resp_data_o;
    logic [AW-1:0]  dc_resp_addr_o;
    logic [DDW-1:0] dc_resp_data_o;
    logic           mem_valid_o, mem_we_o, mem_ready_i;
    logic [AW-1:0]  mem_addr_o;
    logic [DDW-1:0] mem_wdata_o;
    logic           mem_resp_valid_i;
    logic [AW-1:0]  mem_resp_addr_i;
    logic [DDW-1:0] mem_resp_data_i;
    logic           err_o;

    int            n_vec = 0;
    int            n_err = 0;
    bit            auto_resp = 1'b0;
    int            lat = 1;
    int            resp_cnt = 0;
    logic [AW-1:0] pend_addr = '0;

    always #5 clk = ~clk;

    l2_req_arbiter #(.ADDR_BITS(AW), .IC_DW(IDW), .DC_DW(DDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_rd_valid_i(ic_rd_valid_i), .ic_rd_addr_i(ic_rd_addr_i), .ic_rd_ready_o(ic_rd_ready_o),
        .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o),
        .dc_rd_valid_i(dc_rd_valid_i), .dc_rd_addr_i(dc_rd_addr_i), .dc_rd_ready_o(dc_rd_ready_o),
        .dc_resp_valid_o(dc_resp_valid_o), .dc_resp_addr_o(dc_resp_addr_o), .dc_resp_data_o(dc_resp_data_o),
        .dc_wr_valid_i(dc_wr_valid_i), .dc_wr_addr_i(dc_wr_addr_i), .dc_wr_data_i(dc_wr_data_i),
        .dc_wr_ready_o(dc_wr_ready_o),
        .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_addr_i(mem_resp_addr_i),
        .mem_resp_data_i(mem_resp_data_i), .err_o(err_o)
    );

    function automatic logic [DDW-1:0] pat(input logic [AW-1:0] a);
        return {8{a ^ 32'hA5A5_A5A5}};
    endfunction

    task automatic drive_idle();
        ic_rd_valid_i = 0; ic_rd_addr_i = '0;
        dc_rd_valid_i = 0; dc_rd_addr_i = '0;
        dc_wr_valid_i = 0; dc_wr_addr_i = '0; dc_wr_data_i = '0;
        mem_ready_i = 0; mem_resp_valid_i = 0; mem_resp_addr_i = '0; mem_resp_data_i = '0;
    endtask

    // Called mid-cycle; advances to just after the next rising edge and plays the memory.
    task automatic tick();
        logic          hs;
        logic [AW-1:0] a;
        hs = mem_valid_o && mem_ready_i && !mem_we_o;
        a  = mem_addr_o;
        @(posedge clk);
        #1;
        mem_resp_valid_i = 0;
        if (auto_resp) begin
            if (hs) begin
                resp_cnt  = lat;
                pend_addr = a;
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_resp_valid_i = 1;
                    mem_resp_addr_i  = pend_addr;
                    mem_resp_data_i  = pat(pend_addr);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        resp_cnt = 0;
        auto_resp = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive_idle();
        #2;
        n_vec++;
        if ({ic_rd_ready_o, dc_rd_ready_o, dc_wr_ready_o, ic_resp_valid_o, dc_resp_valid_o,
             mem_valid_o, mem_we_o, err_o} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {ic_rd_ready_o, dc_rd_ready_o,
                     dc_wr_ready_o, ic_resp_valid_o, dc_resp_valid_o, mem_valid_o, mem_we_o, err_o});
        end
        n_vec++;
        if (mem_addr_o !== '0 || mem_wdata_o !== '0 || dc_resp_addr_o !== '0 ||
            dc_resp_data_o !== '0 || ic_resp_data_o !== '0) begin
            n_err++;
            $display("FAIL reset_data: got addr %h expected 0", mem_addr_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_single_ic_read();
        int hs_cyc = -1, resp_cyc = -1, ic_p = 0, dc_p = 0;
        logic [DDW-1:0] exp_d;
        logic [IDW-1:0] got = '0, exp_ic;
        logic g;
        exp_d  = pat(32'h40);
        exp_ic = exp_d[IDW-1:0];
        auto_resp = 1; lat = 3; mem_ready_i = 1;
        ic_rd_valid_i = 1; ic_rd_addr_i = 32'h40;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_valid_o && mem_ready_i) hs_cyc = c;
            if (ic_resp_valid_o) begin ic_p++; resp_cyc = c; got = ic_resp_data_o; end
            if (dc_resp_valid_o) dc_p++;
            g = ic_rd_ready_o;
            tick();
            if (g) ic_rd_valid_i = 0;
        end
        n_vec++;
        if (ic_p != 1 || dc_p != 0) begin
            n_err++;
            $display("FAIL ic_read_pulses: got ic=%0d dc=%0d expected ic=1 dc=0", ic_p, dc_p);
        end
        n_vec++;
        if (resp_cyc - hs_cyc != 3) begin
            n_err++;
            $display("FAIL ic_read_latency: got %0d expected 3", resp_cyc - hs_cyc);
        end
        n_vec++;
        if (got !== exp_ic) begin
            n_err++;
            $display("FAIL ic_read_data: got %h expected %h", got, exp_ic);
        end
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("FAIL ic_read_err: got %b expected 0", err_o);
        end
    endtask

    task automatic test_all_three();
        int order[$];
        int exp_order[3];
        logic [2:0] g;
`ifdef L2_ARB_WRITE_PRIO_EN
        exp_order = '{2, 0, 1};
`else
        exp_order = '{0, 1, 2};
`endif
        do_reset();
        auto_resp = 1; lat = 1; mem_ready_i = 1;
        ic_rd_valid_i = 1; ic_rd_addr_i = 32'h100;
        dc_rd_valid_i = 1; dc_rd_addr_i = 32'h200;
        dc_wr_valid_i = 1; dc_wr_addr_i = 32'h300; dc_wr_data_i = pat(32'h300);
        for (int c = 0; c < 40 && order.size() < 3; c++) begin
            @(negedge clk);
            g = {dc_wr_ready_o, dc_rd_ready_o, ic_rd_ready_o};
            n_vec++;
            if ($countones(g) > 1) begin
                n_err++;
                $display("FAIL one_grant: got %b expected at most one ready", g);
            end
            if (g != 3'b000) order.push_back(g[0] ? 0 : (g[1] ? 1 : 2));
            tick();
            if (g[0]) ic_rd_valid_i = 0;
            if (g[1]) dc_rd_valid_i = 0;
            if (g[2]) dc_wr_valid_i = 0;
        end
        n_vec++;
        if (order.size() != 3) begin
            n_err++;
            $display("FAIL grant_count: got %0d expected 3", order.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (order[i] != exp_order[i]) begin
                    n_err++;
                    $display("FAIL grant_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
                end
            end
        end
        repeat (6) begin @(negedge clk); tick(); end
    endtask

    task automatic test_back_to_back();
        int gcyc[$];
        int k = 0;
        logic [AW-1:0] cur = '0;
        logic g;
        mem_ready_i = 1;
        dc_wr_valid_i = 1; dc_wr_addr_i = 32'h1000; dc_wr_data_i = pat(32'h1000);
        for (int c = 0; c < 20 && gcyc.size() < 4; c++) begin
            @(negedge clk);
            if (mem_valid_o) begin
                n_vec++;
                if (mem_we_o !== 1'b1 || mem_addr_o !== cur || mem_wdata_o !== pat(cur)) begin
                    n_err++;
                    $display("FAIL b2b_mem: got we=%b addr=%h expected we=1 addr=%h", mem_we_o, mem_addr_o, cur);
                end
            end
            g = dc_wr_ready_o;
            if (g) begin gcyc.push_back(c); cur = dc_wr_addr_i; end
            tick();
            if (g) begin
                k++;
                dc_wr_addr_i = 32'h1000 + 32'(k * 64);
                dc_wr_data_i = pat(dc_wr_addr_i);
            end
        end
        dc_wr_valid_i = 0;
        n_vec++;
        if (gcyc.size() != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d expected 4", gcyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_vec++;
                if (gcyc[i] - gcyc[i-1] != 2) begin
                    n_err++;
                    $display("FAIL b2b_spacing: got %0d expected 2", gcyc[i] - gcyc[i-1]);
                end
            end
        end
        repeat (3) begin @(negedge clk); tick(); end
    endtask

    task automatic test_backpressure();
        bit seen = 0;
        logic g;
        auto_resp = 1; lat = 2; mem_ready_i = 0;
        dc_wr_valid_i = 1; dc_wr_addr_i = 32'h2000; dc_wr_data_i = pat(32'h2000);
        @(negedge clk);
        n_vec++;
        if (dc_wr_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL bp_accept: got %b expected 1", dc_wr_ready_o);
        end
        tick();
        dc_wr_valid_i = 0;
        ic_rd_valid_i = 1; ic_rd_addr_i = 32'h2040;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (mem_valid_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h2000 ||
                mem_wdata_o !== pat(32'h2000)) begin
                n_err++;
                $display("FAIL bp_hold: got v=%b addr=%h expected v=1 addr=00002000", mem_valid_o, mem_addr_o);
            end
            n_vec++;
            if ({ic_rd_ready_o, dc_rd_ready_o, dc_wr_ready_o} !== 3'b000) begin
                n_err++;
                $display("FAIL bp_ready: got %b expected 000", {ic_rd_ready_o, dc_rd_ready_o, dc_wr_ready_o});
            end
            tick();
        end
        mem_ready_i = 1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            g = ic_rd_ready_o;
            if (ic_resp_valid_o) seen = 1;
            tick();
            if (g) ic_rd_valid_i = 0;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL bp_followup: got no ic response expected one");
        end
    endtask

    task automatic ic_read_to_wait(input logic [AW-1:0] a);
        ic_rd_valid_i = 1; ic_rd_addr_i = a; mem_ready_i = 1;
        @(negedge clk);
        n_vec++;
        if (ic_rd_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL ic_grant: got %b expected 1", ic_rd_ready_o);
        end
        tick();
        ic_rd_valid_i = 0;
    endtask

    task automatic test_mismatch();
        logic [DDW-1:0] exp_d;
        logic [IDW-1:0] exp_ic;
        exp_d = pat(32'h40);
        exp_ic = exp_d[IDW-1:0];
        auto_resp = 0;
        ic_read_to_wait(32'h40);
        @(negedge clk);
        tick();
        mem_resp_valid_i = 1; mem_resp_addr_i = 32'h80; mem_resp_data_i = pat(32'h80);
        @(negedge clk);
        n_vec++;
        if (ic_resp_valid_o !== 1'b0 || dc_resp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL mismatch_drop: got %b%b expected 00", ic_resp_valid_o, dc_resp_valid_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL mismatch_err: got %b expected 1", err_o);
        end
        tick();
        mem_resp_valid_i = 1; mem_resp_addr_i = 32'h40; mem_resp_data_i = pat(32'h40);
        @(negedge clk);
        n_vec++;
        if (ic_resp_valid_o !== 1'b1 || ic_resp_data_o !== exp_ic) begin
            n_err++;
            $display("FAIL mismatch_route: got v=%b d=%h expected v=1 d=%h", ic_resp_valid_o, ic_resp_data_o, exp_ic);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (err_o !== 1'b1 || ic_resp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_sticky: got err=%b v=%b expected err=1 v=0", err_o, ic_resp_valid_o);
        end
        tick();
    endtask

    task automatic test_unexpected_resp();
        do_reset();
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("FAIL err_cleared: got %b expected 0", err_o);
        end
        mem_resp_valid_i = 1; mem_resp_addr_i = 32'h40; mem_resp_data_i = pat(32'h40);
        @(negedge clk);
        n_vec++;
        if (ic_resp_valid_o !== 1'b0 || dc_resp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_resp_drop: got %b%b expected 00", ic_resp_valid_o, dc_resp_valid_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL idle_resp_err: got %b expected 1", err_o);
        end
        tick();
        // Response landing on the read handshake cycle itself.
        do_reset();
        ic_read_to_wait(32'h40);
        mem_resp_valid_i = 1; mem_resp_addr_i = 32'h40; mem_resp_data_i = pat(32'h40);
        @(negedge clk);
        n_vec++;
        if (mem_valid_o !== 1'b1 || ic_resp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL zero_lat_drop: got mv=%b v=%b expected mv=1 v=0", mem_valid_o, ic_resp_valid_o);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL zero_lat_err: got %b expected 1", err_o);
        end
        tick();
        mem_resp_valid_i = 1; mem_resp_addr_i = 32'h40; mem_resp_data_i = pat(32'h40);
        @(negedge clk);
        n_vec++;
        if (ic_resp_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL zero_lat_later: got %b expected 1", ic_resp_valid_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ic_seen = 0, dc_seen = 0;
        logic gd, gi;
        do_reset();
        ic_read_to_wait(32'h40);
        @(negedge clk);
        tick();
        @(negedge clk);
        n_vec++;
        if (mem_addr_o !== 32'h40) begin
            n_err++;
            $display("FAIL mid_pre_addr: got %h expected 00000040", mem_addr_o);
        end
        #1;
        rst_n = 0;
        drive_idle();
        resp_cnt = 0;
        #1;
        n_vec++;
        if ({ic_rd_ready_o, dc_rd_ready_o, dc_wr_ready_o, ic_resp_valid_o, dc_resp_valid_o,
             mem_valid_o, mem_we_o, err_o} !== 8'h00 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin
            n_err++;
            $display("FAIL mid_reset_async: got addr=%h mv=%b expected all zero", mem_addr_o, mem_valid_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
        ic_rd_valid_i = 1; ic_rd_addr_i = 32'h300;
        dc_rd_valid_i = 1; dc_rd_addr_i = 32'h340;
        mem_ready_i = 1;
        @(negedge clk);
        n_vec++;
        if ({dc_wr_ready_o, dc_rd_ready_o, ic_rd_ready_o} !== 3'b001) begin
            n_err++;
            $display("FAIL mid_first_grant: got %b expected 001", {dc_wr_ready_o, dc_rd_ready_o, ic_rd_ready_o});
        end
        tick();
        ic_rd_valid_i = 0;
        auto_resp = 1; lat = 1;
        for (int c = 0; c < 30 && !dc_seen; c++) begin
            @(negedge clk);
            gd = dc_rd_ready_o;
            gi = ic_rd_ready_o;
            if (ic_resp_valid_o) ic_seen = 1;
            if (dc_resp_valid_o) dc_seen = 1;
            tick();
            if (gd) dc_rd_valid_i = 0;
            if (gi) ic_rd_valid_i = 0;
        end
        n_vec++;
        if (!ic_seen || !dc_seen) begin
            n_err++;
            $display("FAIL mid_drain: got ic=%0d dc=%0d expected both 1", ic_seen, dc_seen);
        end
    endtask

    task automatic test_random();
        bit             v[3];
        logic [AW-1:0]  ra[3];
        logic [DDW-1:0] wd = '0, m_wd = '0;
        logic [AW-1:0]  m_addr = '0;
        bit             busy = 0, issued = 0, m_we = 0, exp_ir, exp_dr;
        int             src = 0, ptr = 0;
        int             order[3];
        logic [2:0]     exp_g, g;
        logic [DDW-1:0] rd;
        do_reset();
        auto_resp = 1;
        for (int i = 0; i < 3; i++) begin v[i] = 0; ra[i] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!v[i] && $urandom_range(1, 0) == 1) begin
                    v[i]  = 1;
                    ra[i] = $urandom() & 32'hFFFF_FFC0;
                    if (i == 2) wd = {8{$urandom()}};
                end
            end
            ic_rd_valid_i = v[0]; ic_rd_addr_i = ra[0];
            dc_rd_valid_i = v[1]; dc_rd_addr_i = ra[1];
            dc_wr_valid_i = v[2]; dc_wr_addr_i = ra[2]; dc_wr_data_i = wd;
            mem_ready_i = ($urandom_range(9, 0) < 7);
            lat = $urandom_range(4, 1);
            @(negedge clk);
            exp_g = 3'b000;
            if (!busy) begin
`ifdef L2_ARB_WRITE_PRIO_EN
                order = '{2, (ptr == 1) ? 1 : 0, (ptr == 1) ? 0 : 1};
`else
                order = '{ptr, (ptr + 1) % 3, (ptr + 2) % 3};
`endif
                for (int k = 0; k < 3; k++)
                    if (exp_g == 3'b000 && v[order[k]]) exp_g[order[k]] = 1'b1;
            end
            g = {dc_wr_ready_o, dc_rd_ready_o, ic_rd_ready_o};
            n_vec++;
            if (g !== exp_g) begin
                n_err++;
                $display("FAIL rand_grant cyc=%0d: got %b expected %b", cyc, g, exp_g);
            end
            n_vec++;
            if (mem_valid_o !== (busy && !issued)) begin
                n_err++;
                $display("FAIL rand_mem_valid cyc=%0d: got %b expected %b", cyc, mem_valid_o, busy && !issued);
            end else if (busy && !issued) begin
                n_vec++;
                if (mem_addr_o !== m_addr || mem_we_o !== m_we || (m_we && mem_wdata_o !== m_wd)) begin
                    n_err++;
                    $display("FAIL rand_mem_req cyc=%0d: got addr=%h we=%b expected addr=%h we=%b",
                             cyc, mem_addr_o, mem_we_o, m_addr, m_we);
                end
            end
            exp_ir = busy && issued && mem_resp_valid_i && src == 0;
            exp_dr = busy && issued && mem_resp_valid_i && src == 1;
            rd = pat(m_addr);
            n_vec++;
            if ({ic_resp_valid_o, dc_resp_valid_o} !== {exp_ir, exp_dr}) begin
                n_err++;
                $display("FAIL rand_resp_valid cyc=%0d: got %b%b expected %b%b", cyc,
                         ic_resp_valid_o, dc_resp_valid_o, exp_ir, exp_dr);
            end else if (exp_ir || exp_dr) begin
                n_vec++;
                if ((exp_ir && ic_resp_data_o !== rd[IDW-1:0]) ||
                    (exp_dr && (dc_resp_data_o !== rd || dc_resp_addr_o !== m_addr))) begin
                    n_err++;
                    $display("FAIL rand_resp_data cyc=%0d: got addr=%h expected addr=%h", cyc, dc_resp_addr_o, m_addr);
                end
            end
            if (!busy) begin
                if (exp_g != 3'b000) begin
                    src    = exp_g[0] ? 0 : (exp_g[1] ? 1 : 2);
                    busy   = 1;
                    issued = 0;
                    m_addr = ra[src];
                    m_we   = (src == 2);
                    m_wd   = wd;
                    v[src] = 0;
`ifdef L2_ARB_WRITE_PRIO_EN
                    if (src != 2) ptr = (src == 0) ? 1 : 0;
`else
                    ptr = (src + 1) % 3;
`endif
                end
            end else if (!issued) begin
                if (mem_ready_i) begin
                    if (m_we) busy = 0;
                    else issued = 1;
                end
            end else if (mem_resp_valid_i) begin
                busy = 0;
            end
            tick();
        end
        n_vec++;
        if (err_o !== 1'b0) begin
            n_err++;
            $display("FAIL rand_err: got %b expected 0", err_o);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_single_ic_read();
        test_all_three();
        test_back_to_back();
        test_backpressure();
        test_mismatch();
        test_unexpected_resp();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
